// File: rtl/oe_sort8.sv
// Snapshots eight DW-bit elements on start and sorts them in place with an
// odd-even transposition network, one compare/swap phase per clock.
module oe_sort8 #(
    parameter int DW      = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    input  logic [DW-1:0] in5,
    input  logic [DW-1:0] in6,
    input  logic [DW-1:0] in7,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] s0,
    output logic [DW-1:0] s1,
    output logic [DW-1:0] s2,
    output logic [DW-1:0] s3,
    output logic [DW-1:0] s4,
    output logic [DW-1:0] s5,
    output logic [DW-1:0] s6,
    output logic [DW-1:0] s7
);

    typedef enum logic {IDLE, SORT} state_t;

    state_t        state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic          busy_n, done_n;
    logic [DW-1:0] s_r [8];
    logic [DW-1:0] s_n [8];

    // Strict inequality only: equal elements never move.
    function automatic logic out_of_order(input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        return DESCEND ? (lo < hi) : (lo > hi);
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        for (int i = 0; i < 8; i++) s_n[i] = s_r[i];

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SORT;
                    cnt_n   = 3'd0;
                    busy_n  = 1'b1;
                    s_n[0]  = in0;
                    s_n[1]  = in1;
                    s_n[2]  = in2;
                    s_n[3]  = in3;
                    s_n[4]  = in4;
                    s_n[5]  = in5;
                    s_n[6]  = in6;
                    s_n[7]  = in7;
                end
            end
            SORT: begin
                // Even phases pair (0,1)..(6,7); odd phases pair (1,2)..(5,6).
                for (int i = 0; i < 7; i++) begin
                    if ((i[0] == cnt[0]) && out_of_order(s_r[i], s_r[i+1])) begin
                        s_n[i]   = s_r[i+1];
                        s_n[i+1] = s_r[i];
                    end
                end
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < 8; i++) s_r[i] <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            for (int i = 0; i < 8; i++) s_r[i] <= s_n[i];
        end
    end

    assign s0 = s_r[0];
    assign s1 = s_r[1];
    assign s2 = s_r[2];
    assign s3 = s_r[3];
    assign s4 = s_r[4];
    assign s5 = s_r[5];
    assign s6 = s_r[6];
    assign s7 = s_r[7];

endmodule

// File: tb/tb_oe_sort8.sv
// Bench for oe_sort8: ascending and descending instances share stimulus and
// are compared against constant tables and a plain reference sort.
module tb_oe_sort8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in_vec;
    logic        busy_a, done_a, busy_d, done_d;
    logic [3:0]  sa0, sa1, sa2, sa3, sa4, sa5, sa6, sa7;
    logic [3:0]  sd0, sd1, sd2, sd3, sd4, sd5, sd6, sd7;
    logic [31:0] sa_vec, sd_vec;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign sa_vec = {sa7, sa6, sa5, sa4, sa3, sa2, sa1, sa0};
    assign sd_vec = {sd7, sd6, sd5, sd4, sd3, sd2, sd1, sd0};

    oe_sort8 #(.DW(4), .DESCEND(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .in0(in_vec[3:0]), .in1(in_vec[7:4]), .in2(in_vec[11:8]), .in3(in_vec[15:12]),
        .in4(in_vec[19:16]), .in5(in_vec[23:20]), .in6(in_vec[27:24]), .in7(in_vec[31:28]),
        .busy(busy_a), .done(done_a),
        .s0(sa0), .s1(sa1), .s2(sa2), .s3(sa3), .s4(sa4), .s5(sa5), .s6(sa6), .s7(sa7)
    );

    oe_sort8 #(.DW(4), .DESCEND(1'b1)) dut_d (
        .clk(clk), .rst(rst), .start(start),
        .in0(in_vec[3:0]), .in1(in_vec[7:4]), .in2(in_vec[11:8]), .in3(in_vec[15:12]),
        .in4(in_vec[19:16]), .in5(in_vec[23:20]), .in6(in_vec[27:24]), .in7(in_vec[31:28]),
        .busy(busy_d), .done(done_d),
        .s0(sd0), .s1(sd1), .s2(sd2), .s3(sd3), .s4(sd4), .s5(sd5), .s6(sd6), .s7(sd7)
    );

    typedef struct {
        logic [31:0] vin;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [31:0] mk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
        return {a7[3:0], a6[3:0], a5[3:0], a4[3:0], a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
    endfunction

    // Reference: plain selection sort of the eight nibbles.
    function automatic logic [31:0] ref_sort(input logic [31:0] v, input bit desc);
        logic [3:0]  a [8];
        logic [3:0]  t;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[i*4 +: 4];
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++)
                if (desc ? (a[j] > a[i]) : (a[j] < a[i])) begin
                    t = a[i]; a[i] = a[j]; a[j] = t;
                end
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = a[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sort(input logic [31:0] v, input logic [31:0] exp_a,
                           input logic [31:0] exp_d, input string tag);
        int lat;
        int bcnt;
        in_vec = v;
        start  = 1'b1;
        step();
        start  = 1'b0;
        in_vec = $urandom();
        lat  = 0;
        bcnt = 0;
        while (!done_a && lat < 20) begin
            if (busy_a && busy_d) bcnt++;
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_busy_cycles"}, bcnt, 8);
        check({tag, "_done_desc"}, {31'd0, done_d}, 32'd1);
        check({tag, "_asc"}, sa_vec, exp_a);
        check({tag, "_desc"}, sd_vec, exp_d);
        step();
        check({tag, "_done_pulse_end"}, {30'd0, done_a, done_d}, 32'd0);
        check({tag, "_hold_asc"}, sa_vec, exp_a);
    endtask

    initial begin
        int lat;
        int seen;
        int gap;
        logic [31:0] rv;

        tbl[0] = '{mk(7,6,5,4,3,2,1,0), mk(0,1,2,3,4,5,6,7), mk(7,6,5,4,3,2,1,0)};
        tbl[1] = '{mk(3,3,1,'hF,0,1,'hF,3), mk(0,1,1,3,3,3,'hF,'hF), mk('hF,'hF,3,3,3,1,1,0)};
        tbl[2] = '{mk(5,5,5,5,5,5,5,5), mk(5,5,5,5,5,5,5,5), mk(5,5,5,5,5,5,5,5)};
        tbl[3] = '{mk(0,1,2,3,4,5,6,7), mk(0,1,2,3,4,5,6,7), mk(7,6,5,4,3,2,1,0)};
        tbl[4] = '{mk('hF,0,'hF,0,'hF,0,'hF,0), mk(0,0,0,0,'hF,'hF,'hF,'hF), mk('hF,'hF,'hF,'hF,0,0,0,0)};

        // Reset with start held high must not launch a sort.
        rst    = 1'b1;
        start  = 1'b1;
        in_vec = mk(7,6,5,4,3,2,1,0);
        step();
        step();
        check("rst_busy_done", {28'd0, busy_a, done_a, busy_d, done_d}, 32'd0);
        check("rst_s_asc", sa_vec, 32'd0);
        check("rst_s_desc", sd_vec, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("post_rst_idle", {30'd0, busy_a, busy_d}, 32'd0);

        for (int k = 0; k < 5; k++)
            do_sort(tbl[k].vin, tbl[k].exp_a, tbl[k].exp_d, $sformatf("tbl%0d", k));

        // start and new inputs mid-sort are ignored.
        in_vec = mk(7,6,5,4,3,2,1,0);
        start  = 1'b1;
        step();
        start  = 1'b0;
        step(); step(); step();
        in_vec = 32'hFFFF_FFFF;
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat = 4;
        while (!done_a && lat < 20) begin
            step();
            lat++;
        end
        check("midstart_latency", lat, 8);
        check("midstart_asc", sa_vec, mk(0,1,2,3,4,5,6,7));
        check("midstart_desc", sd_vec, mk(7,6,5,4,3,2,1,0));
        step();
        check("midstart_no_restart", {30'd0, busy_a, busy_d}, 32'd0);

        // Reset mid-sort aborts with no done.
        in_vec = mk(7,6,5,4,3,2,1,0);
        start  = 1'b1;
        step();
        start  = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", {30'd0, busy_a, busy_d}, 32'd0);
        check("abort_s_asc", sa_vec, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_a || done_d) seen++;
            step();
        end
        check("abort_no_done", seen, 0);
        do_sort(mk(5,2,7,1,0,6,4,3), mk(0,1,2,3,4,5,6,7), mk(7,6,5,4,3,2,1,0), "after_abort");

        // start held high: back-to-back sorts every 9 edges.
        in_vec = mk(0,1,2,3,4,5,6,7);
        start  = 1'b1;
        step();
        lat = 1;
        while (!done_a && lat < 20) begin
            step();
            lat++;
        end
        check("b2b_first_latency", lat, 9);
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            step();
            gap++;
            while (!done_a && gap < 20) begin
                step();
                gap++;
            end
            check($sformatf("b2b_gap%0d", k), gap, 9);
            check($sformatf("b2b_s%0d", k), sa_vec, mk(0,1,2,3,4,5,6,7));
        end
        start = 1'b0;
        lat = 0;
        while ((busy_a || done_a) && lat < 20) begin
            step();
            lat++;
        end

        for (int k = 0; k < 30; k++) begin
            rv = $urandom();
            do_sort(rv, ref_sort(rv, 1'b0), ref_sort(rv, 1'b1), $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
